// File: rtl/dmem_pkg.sv
// Shared constants for the four-core DRAM port arbiter.
// State and op encodings are plain constants for legacy tools.
package dmem_pkg;

    localparam int NUM_CORES = 4;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_WAIT  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority selector over four requesters.
// Scans rr, rr+1, ... mod 4 and returns the first pending index.
module rr_pick4 (
    input  logic [3:0] pending,
    input  logic [1:0] rr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Descending scan so the nearest slot to rr is the last to assign.
    always_comb begin
        winner = rr;
        valid  = 1'b0;
        idx    = rr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (pending[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises four core request ports onto one DRAM port with
// round-robin fairness and same-address read coalescing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DRAM_LAT = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] AR_1,
    input  logic [WIDTH-1:0] AR_2,
    input  logic [WIDTH-1:0] AR_3,
    input  logic [WIDTH-1:0] AR_4,
    input  logic [WIDTH-1:0] DR_1,
    input  logic [WIDTH-1:0] DR_2,
    input  logic [WIDTH-1:0] DR_3,
    input  logic [WIDTH-1:0] DR_4,
    input  logic             mread_en1,
    input  logic             mread_en2,
    input  logic             mread_en3,
    input  logic             mread_en4,
    input  logic             mwrite_en1,
    input  logic             mwrite_en2,
    input  logic             mwrite_en3,
    input  logic             mwrite_en4,
    input  logic [WIDTH-1:0] MEM,
    output logic [WIDTH-1:0] Addrs,
    output logic [WIDTH-1:0] DataOut,
    output logic             mread_en,
    output logic             mwrite_en,
    output logic [WIDTH-1:0] MEM_1,
    output logic [WIDTH-1:0] MEM_2,
    output logic [WIDTH-1:0] MEM_3,
    output logic [WIDTH-1:0] MEM_4,
    output logic             memAV1,
    output logic             memAV2,
    output logic             memAV3,
    output logic             memAV4
);

    logic [WIDTH-1:0]     ar    [NUM_CORES];
    logic [WIDTH-1:0]     dr    [NUM_CORES];
    logic [WIDTH-1:0]     mem_q [NUM_CORES];
    logic [NUM_CORES-1:0] rd, wr, pend, co, mask, av, av_d;
    logic [1:0]           state, rr, win, pick;
    logic                 pick_v, op;
    logic [3:0]           cnt;

    assign ar[0] = AR_1;
    assign ar[1] = AR_2;
    assign ar[2] = AR_3;
    assign ar[3] = AR_4;
    assign dr[0] = DR_1;
    assign dr[1] = DR_2;
    assign dr[2] = DR_3;
    assign dr[3] = DR_4;

    assign rd = {mread_en4, mread_en3, mread_en2, mread_en1};
    assign wr = {mwrite_en4, mwrite_en3, mwrite_en2, mwrite_en1};

    // A core just served still shows its request for one cycle.
    assign pend = (rd | wr) & ~av_d;

    assign {memAV4, memAV3, memAV2, memAV1} = av;
    assign MEM_1 = mem_q[0];
    assign MEM_2 = mem_q[1];
    assign MEM_3 = mem_q[2];
    assign MEM_4 = mem_q[3];

    rr_pick4 u_pick (
        .pending(pend),
        .rr     (rr),
        .winner (pick),
        .valid  (pick_v)
    );

    // Serve set: winner, plus pure readers of the same address.
    always_comb begin
        co = '0;
        for (int i = 0; i < NUM_CORES; i++)
            co[i] = pend[i] & rd[i] & ~wr[i] & (ar[i] == ar[pick]);
        if (wr[pick])
            co = '0;
        co[pick] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            rr        <= '0;
            win       <= '0;
            op        <= OP_RD;
            mask      <= '0;
            cnt       <= '0;
            av        <= '0;
            av_d      <= '0;
            Addrs     <= '0;
            DataOut   <= '0;
            mread_en  <= 1'b0;
            mwrite_en <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++)
                mem_q[i] <= '0;
        end else begin
            mread_en  <= 1'b0;
            mwrite_en <= 1'b0;
            av        <= '0;
            av_d      <= av;
            unique case (state)
                S_IDLE: begin
                    if (pick_v) begin
                        win   <= pick;
                        op    <= wr[pick] ? OP_WR : OP_RD;
                        mask  <= co;
                        Addrs <= ar[pick];
                        if (wr[pick]) begin
                            DataOut   <= dr[pick];
                            mwrite_en <= 1'b1;
                        end else begin
                            mread_en <= 1'b1;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op == OP_WR) begin
                        av    <= mask;
                        state <= S_DONE;
                    end else begin
                        cnt   <= 4'(DRAM_LAT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        for (int i = 0; i < NUM_CORES; i++)
                            if (mask[i])
                                mem_q[i] <= MEM;
                        av    <= mask;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    rr    <= win + 2'd1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// request rounds checked against a transaction-level arbitration model.
module tb_dmem_arbiter;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ar [4];
    logic [7:0] dr [4];
    logic [3:0] rd = '0;
    logic [3:0] wr = '0;
    logic [7:0] mem, addrs, data_out;
    logic       mrd, mwr;
    logic [7:0] mem_o [4];
    logic [3:0] av;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(8), .DRAM_LAT(LAT)) dut (
        .Clk(clk), .Rst(rst),
        .AR_1(ar[0]), .AR_2(ar[1]), .AR_3(ar[2]), .AR_4(ar[3]),
        .DR_1(dr[0]), .DR_2(dr[1]), .DR_3(dr[2]), .DR_4(dr[3]),
        .mread_en1(rd[0]), .mread_en2(rd[1]),
        .mread_en3(rd[2]), .mread_en4(rd[3]),
        .mwrite_en1(wr[0]), .mwrite_en2(wr[1]),
        .mwrite_en3(wr[2]), .mwrite_en4(wr[3]),
        .MEM(mem), .Addrs(addrs), .DataOut(data_out),
        .mread_en(mrd), .mwrite_en(mwr),
        .MEM_1(mem_o[0]), .MEM_2(mem_o[1]),
        .MEM_3(mem_o[2]), .MEM_4(mem_o[3]),
        .memAV1(av[0]), .memAV2(av[1]),
        .memAV3(av[2]), .memAV4(av[3])
    );

    // DRAM model: data valid only in the cycle LAT after the issue cycle.
    logic [7:0] dram  [256];
    logic [7:0] mdram [256];
    int         cyc = 0;
    int         rdy = -1;
    logic [7:0] raddr = '0;
    int         rd_pulses = 0;
    logic [7:0] wlog [$];

    assign mem = (cyc == rdy) ? dram[raddr] : 8'hEE;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mrd) begin
            rdy   <= cyc + LAT;
            raddr <= addrs;
            rd_pulses++;
        end
        if (mwr) begin
            dram[addrs] = data_out;
            wlog.push_back(addrs);
        end
    end

    // Reference model state
    int         m_rr;
    logic [7:0] mem_exp [4];
    int         n_exp;
    int         e_t    [4];
    logic [3:0] e_mask [4];
    bit         e_rd   [4];
    logic [7:0] e_addr [4];
    logic [7:0] e_data [4];

    task automatic model_round();
        bit [3:0] p;
        int       kind [4];
        int       w, t, lat;
        for (int i = 0; i < 4; i++) begin
            kind[i] = wr[i] ? 2 : (rd[i] ? 1 : 0);
            p[i]    = (kind[i] != 0);
        end
        n_exp = 0;
        t     = 0;
        while (p != 0) begin
            w = 0;
            for (int j = 3; j >= 0; j--)
                if (p[(m_rr + j) % 4]) w = (m_rr + j) % 4;
            e_rd[n_exp]      = (kind[w] == 1);
            e_addr[n_exp]    = ar[w];
            e_mask[n_exp]    = '0;
            e_mask[n_exp][w] = 1'b1;
            if (e_rd[n_exp]) begin
                for (int i = 0; i < 4; i++)
                    if (p[i] && kind[i] == 1 && ar[i] == ar[w])
                        e_mask[n_exp][i] = 1'b1;
                e_data[n_exp] = mdram[ar[w]];
                lat = LAT;
            end else begin
                e_data[n_exp] = dr[w];
                mdram[ar[w]]  = dr[w];
                lat = 0;
            end
            t = (n_exp == 0) ? 2 + lat : t + 3 + lat;
            e_t[n_exp] = t;
            p     = p & ~e_mask[n_exp];
            m_rr  = (w + 1) % 4;
            n_exp = n_exp + 1;
        end
    endtask

    // Requests are applied now (IDLE cycle 0); each served core drops
    // its request two cycles after its completion pulse.
    task automatic run_round();
        int         drop_k [4];
        int         kmax;
        logic [3:0] ea;
        bit         er, ew;
        logic [7:0] eaddr, edata;
        model_round();
        for (int i = 0; i < 4; i++) drop_k[i] = -1;
        kmax = ((n_exp == 0) ? 0 : e_t[n_exp-1]) + 3;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            ea = '0; er = 1'b0; ew = 1'b0; eaddr = '0; edata = '0;
            for (int j = 0; j < n_exp; j++) begin
                if (k == e_t[j]) begin
                    ea = e_mask[j];
                    for (int i = 0; i < 4; i++)
                        if (e_mask[j][i]) begin
                            drop_k[i] = k + 2;
                            if (e_rd[j]) mem_exp[i] = e_data[j];
                        end
                end
                if (e_rd[j] && k == e_t[j] - 1 - LAT) begin
                    er = 1'b1; eaddr = e_addr[j];
                end
                if (!e_rd[j] && k == e_t[j] - 1) begin
                    ew = 1'b1; eaddr = e_addr[j]; edata = e_data[j];
                end
            end
            checks++;
            if (av !== ea) begin
                errors++;
                $display("FAIL memav k=%0d got %b exp %b", k, av, ea);
            end
            checks++;
            if ({mrd, mwr} !== {er, ew}) begin
                errors++;
                $display("FAIL strobes k=%0d got rd=%b wr=%b exp rd=%b wr=%b",
                         k, mrd, mwr, er, ew);
            end
            if (er || ew) begin
                checks++;
                if (addrs !== eaddr) begin
                    errors++;
                    $display("FAIL addrs k=%0d got %h exp %h", k, addrs, eaddr);
                end
            end
            if (ew) begin
                checks++;
                if (data_out !== edata) begin
                    errors++;
                    $display("FAIL dataout k=%0d got %h exp %h",
                             k, data_out, edata);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_o[i] !== mem_exp[i]) begin
                    errors++;
                    $display("FAIL mem%0d k=%0d got %h exp %h",
                             i + 1, k, mem_o[i], mem_exp[i]);
                end
            end
            for (int i = 0; i < 4; i++)
                if (k == drop_k[i]) begin
                    rd[i] = 1'b0;
                    wr[i] = 1'b0;
                end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({addrs, data_out, mrd, mwr, av} !== '0) begin
            errors++;
            $display("FAIL reset_outs got a=%h d=%h rd=%b wr=%b av=%b exp 0",
                     addrs, data_out, mrd, mwr, av);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_o[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_mem%0d got %h exp 00", i + 1, mem_o[i]);
            end
        end
        rst  = 1'b0;
        m_rr = 0;
        for (int i = 0; i < 4; i++) mem_exp[i] = 8'h00;
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 2; r++) begin
            wlog.delete();
            for (int i = 0; i < 4; i++) begin
                ar[i] = 8'(i + 1);
                dr[i] = 8'(8'h11 * (i + 1));
                wr[i] = 1'b1;
            end
            run_round();
            checks++;
            if (wlog.size() != 4) begin
                errors++;
                $display("FAIL rr_count got %0d exp 4", wlog.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (wlog[i] !== 8'(i + 1)) begin
                        errors++;
                        $display("FAIL rr_order%0d got %h exp %h",
                                 i, wlog[i], 8'(i + 1));
                    end
                end
            end
        end
    endtask

    task automatic test_coalesce();
        int p0;
        p0 = rd_pulses;
        ar[0] = 8'h20; ar[1] = 8'h20; ar[3] = 8'h20; ar[2] = 8'h00;
        rd = 4'b1011;
        run_round();
        checks++;
        if (rd_pulses - p0 != 1) begin
            errors++;
            $display("FAIL coalesce_pulses got %0d exp 1", rd_pulses - p0);
        end
    endtask

    task automatic test_rw_same_addr();
        ar[1] = 8'h30; dr[1] = 8'h5A; wr[1] = 1'b1;
        ar[2] = 8'h30; rd[2] = 1'b1;
        run_round();
        checks++;
        if (mem_o[2] !== 8'h5A) begin
            errors++;
            $display("FAIL rw_same got %h exp 5a", mem_o[2]);
        end
    endtask

    task automatic test_single_read();
        int p0;
        dram[8'h10]  = 8'hA5;
        mdram[8'h10] = 8'hA5;
        p0 = rd_pulses;
        ar[0] = 8'h10; rd[0] = 1'b1;
        run_round();
        checks++;
        if (mem_o[0] !== 8'hA5 || rd_pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_read got %h/%0d exp a5/1",
                     mem_o[0], rd_pulses - p0);
        end
    endtask

    task automatic test_both_enables();
        int p0;
        p0 = rd_pulses;
        ar[3] = 8'h40; dr[3] = 8'h77; rd[3] = 1'b1; wr[3] = 1'b1;
        run_round();
        checks++;
        if (dram[8'h40] !== 8'h77 || rd_pulses != p0) begin
            errors++;
            $display("FAIL both_en got %h/%0d exp 77/0",
                     dram[8'h40], rd_pulses - p0);
        end
    endtask

    task automatic test_reset_wait();
        ar[2] = 8'h60; dr[2] = 8'($urandom); wr[2] = 1'b1;
        run_round();
        ar[1] = 8'h50; ar[3] = 8'h51;
        rd = 4'b1010;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({addrs, data_out, mrd, mwr, av} !== '0) begin
            errors++;
            $display("FAIL async_rst got a=%h d=%h rd=%b wr=%b av=%b exp 0",
                     addrs, data_out, mrd, mwr, av);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_o[i] !== 8'h00) begin
                errors++;
                $display("FAIL async_rst_mem%0d got %h exp 00", i + 1, mem_o[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (av !== 4'b0000) begin
                errors++;
                $display("FAIL rst_noav got %b exp 0000", av);
            end
        end
        rst  = 1'b0;
        m_rr = 0;
        for (int i = 0; i < 4; i++) mem_exp[i] = 8'h00;
        run_round();
    endtask

    task automatic test_random();
        int kind;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 4; i++) begin
                kind  = int'($urandom_range(0, 3));
                ar[i] = 8'h20 + 8'($urandom_range(0, 3));
                dr[i] = 8'($urandom);
                rd[i] = (kind == 1 || kind == 3);
                wr[i] = (kind >= 2);
            end
            run_round();
        end
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (dram[a] !== mdram[a]) begin
                errors++;
                $display("FAIL dram[%h] got %h exp %h", a, dram[a], mdram[a]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ar[i] = '0;
            dr[i] = '0;
        end
        for (int a = 0; a < 256; a++) begin
            dram[a]  = 8'($urandom);
            mdram[a] = dram[a];
        end
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_coalesce();
        test_rw_same_addr();
        test_single_read();
        test_both_enables();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
